framebuffer_tile_store: RTL and testbench

// On-chip tile colour buffer directly downstream of the pixel pipeline. Serves the

---
 rtl/framebuffer_tile_store_if.sv | 19 +
 rtl/framebuffer_tile_store.sv | 201 ++++++++++++++++++++
 tb/tb_framebuffer_tile_store.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/framebuffer_tile_store_if.sv
// ----------------------------------------------------------------------------
// framebuffer_tile_store_if
// AXI-Stream style bus carrying tile words out of the tile colour buffer.
//   tvalid  master -> slave   beat present
//   tready  slave  -> master  beat accepted when tvalid & tready
//   tlast   master -> slave   last word of the tile
//   tdata   master -> slave   STREAM_WIDTH bits, pixel 0 of the word in LSBs
// ----------------------------------------------------------------------------
interface framebuffer_tile_store_if #(
   parameter int STREAM_WIDTH = 64
);
   logic                    tvalid;
   logic                    tready;
   logic                    tlast;
   logic [STREAM_WIDTH-1:0] tdata;

   modport master (output tvalid, output tlast, output tdata, input tready);
   modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/framebuffer_tile_store.sv
// ----------------------------------------------------------------------------
// framebuffer_tile_store
// On-chip tile colour buffer sitting behind the pixel pipeline. Serves a
// 1-cycle-latency pixel read port and a per-pixel write port, and on command
// either fills the whole tile with a clear colour or streams the tile out.
// Storage is word-organised: one word holds PIXEL_PER_BEAT pixels.
//   aclk / resetn        clock, async active-low reset
//   confClearColor       fill colour, sampled when apply is taken
//   apply / commit       start clear / start stream-out (ignored while busy)
//   busy                 high while a clear or stream-out is in progress
//   colorIndexRead       pixel read index, colorIn valid one cycle later
//   colorIndexWrite      pixel write index, with colorWriteEnable / colorOut
//   m_axis               tile stream (master side)
// ----------------------------------------------------------------------------
module framebuffer_tile_store #(
   parameter int FRAMEBUFFER_INDEX_WIDTH = 14,
   parameter int PIXEL_WIDTH             = 32,
   parameter int PIXEL_PER_BEAT          = 2
) (
   input  logic                               aclk,
   input  logic                               resetn,
   input  logic [PIXEL_WIDTH-1:0]             confClearColor,
   input  logic                               apply,
   input  logic                               commit,
   output logic                               busy,
   input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] colorIndexRead,
   output logic [PIXEL_WIDTH-1:0]             colorIn,
   input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] colorIndexWrite,
   input  logic                               colorWriteEnable,
   input  logic [PIXEL_WIDTH-1:0]             colorOut,
   framebuffer_tile_store_if.master           m_axis
);
   localparam int IW           = FRAMEBUFFER_INDEX_WIDTH;
   localparam int PW           = PIXEL_WIDTH;
   localparam int PPB          = PIXEL_PER_BEAT;
   localparam int STREAM_WIDTH = PW * PPB;
   localparam int LANE_BITS    = $clog2(PPB);
   localparam int WORD_W       = IW - LANE_BITS;
   localparam int WORDS        = (2 ** IW) / PPB;
   localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS - 1);
   localparam logic [IW-1:0]     LANE_MASK = IW'(PPB - 1);

   typedef enum logic [1:0] {IDLE, CLEAR, COMMIT} state_t;

   logic [STREAM_WIDTH-1:0] mem_q [WORDS];

   state_t                  state_q;
   logic                    busy_q;
   logic [WORD_W-1:0]       ctr_q;
   logic [PW-1:0]           clear_q;
   logic [PW-1:0]           color_in_q;
   // RAM read pipeline: word read last cycle lands in ram_word_q
   logic                    rd_pend_q;
   logic                    rd_last_q;
   logic                    rd_done_q;
   logic [STREAM_WIDTH-1:0] ram_word_q;
   // output register plus one skid entry
   logic                    tvalid_q;
   logic                    tlast_q;
   logic [STREAM_WIDTH-1:0] tdata_q;
   logic                    skid_vld_q;
   logic                    skid_last_q;
   logic [STREAM_WIDTH-1:0] skid_data_q;

   logic [WORD_W-1:0]       rd_word_d;
   logic [WORD_W-1:0]       wr_word_d;
   logic [PW-1:0]           rd_pix_d;
   logic                    pop_d;
   logic [1:0]              occ_d;
   logic                    rd_issue_d;

   assign rd_word_d = WORD_W'(colorIndexRead >> LANE_BITS);
   assign wr_word_d = WORD_W'(colorIndexWrite >> LANE_BITS);
   assign pop_d     = tvalid_q & m_axis.tready;
   // Words held or in flight; a read may only issue if after this cycle's
   // accept there is still room for it when it lands next cycle.
   assign occ_d      = 2'(tvalid_q) + 2'(skid_vld_q) + 2'(rd_pend_q);
   assign rd_issue_d = (state_q == COMMIT) && !rd_done_q &&
                       ((occ_d - 2'(pop_d)) < 2'd2);

   always_comb begin
      rd_pix_d = '0;
      for (int l = 0; l < PPB; l++) begin
         if ((colorIndexRead & LANE_MASK) == IW'(l)) begin
            rd_pix_d = mem_q[rd_word_d][l*PW +: PW];
         end
      end
      // same-cycle write to the read index: return the new pixel
      if ((state_q == IDLE) && colorWriteEnable && (colorIndexWrite == colorIndexRead)) begin
         rd_pix_d = colorOut;
      end
   end

   // RAM: clear fill, per-lane pixel writes, stream-out word reads (not reset)
   always_ff @(posedge aclk) begin
      if (state_q == CLEAR) begin
         mem_q[ctr_q] <= {PPB{clear_q}};
      end else if ((state_q == IDLE) && colorWriteEnable) begin
         for (int l = 0; l < PPB; l++) begin
            if ((colorIndexWrite & LANE_MASK) == IW'(l)) begin
               mem_q[wr_word_d][l*PW +: PW] <= colorOut;
            end
         end
      end
      if (rd_issue_d) begin
         ram_word_q <= mem_q[ctr_q];
      end
   end

   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         ctr_q       <= '0;
         clear_q     <= '0;
         color_in_q  <= '0;
         rd_pend_q   <= 1'b0;
         rd_last_q   <= 1'b0;
         rd_done_q   <= 1'b0;
         tvalid_q    <= 1'b0;
         tlast_q     <= 1'b0;
         tdata_q     <= '0;
         skid_vld_q  <= 1'b0;
         skid_last_q <= 1'b0;
         skid_data_q <= '0;
      end else begin
         color_in_q <= rd_pix_d;
         case (state_q)
            IDLE: begin
               if (apply) begin
                  state_q <= CLEAR;
                  busy_q  <= 1'b1;
                  ctr_q   <= '0;
                  clear_q <= confClearColor;
               end else if (commit) begin
                  state_q   <= COMMIT;
                  busy_q    <= 1'b1;
                  ctr_q     <= '0;
                  rd_done_q <= 1'b0;
               end
            end
            CLEAR: begin
               if (ctr_q == LAST_WORD) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  ctr_q <= ctr_q + WORD_W'(1);
               end
            end
            COMMIT: begin
               rd_pend_q <= rd_issue_d;
               if (rd_issue_d) begin
                  rd_last_q <= (ctr_q == LAST_WORD);
                  if (ctr_q == LAST_WORD) begin
                     rd_done_q <= 1'b1;
                  end else begin
                     ctr_q <= ctr_q + WORD_W'(1);
                  end
               end
               // Output register refills from the skid first, then from RAM;
               // a landing word that cannot reach the output parks in the skid.
               if (pop_d || !tvalid_q) begin
                  if (skid_vld_q) begin
                     tvalid_q    <= 1'b1;
                     tdata_q     <= skid_data_q;
                     tlast_q     <= skid_last_q;
                     skid_vld_q  <= rd_pend_q;
                     skid_data_q <= ram_word_q;
                     skid_last_q <= rd_last_q;
                  end else if (rd_pend_q) begin
                     tvalid_q <= 1'b1;
                     tdata_q  <= ram_word_q;
                     tlast_q  <= rd_last_q;
                  end else begin
                     tvalid_q <= 1'b0;
                     tlast_q  <= 1'b0;
                  end
               end else if (rd_pend_q) begin
                  skid_vld_q  <= 1'b1;
                  skid_data_q <= ram_word_q;
                  skid_last_q <= rd_last_q;
               end
               if (pop_d && tlast_q) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy          = busy_q;
   assign colorIn       = color_in_q;
   assign m_axis.tvalid = tvalid_q;
   assign m_axis.tlast  = tlast_q;
   assign m_axis.tdata  = tdata_q;
endmodule

// File: tb/tb_framebuffer_tile_store.sv
// ----------------------------------------------------------------------------
// tb_framebuffer_tile_store
// Directed bench for an 8-word tile (16 pixels, 2 pixels per word). Stimulus
// pushes expected stream beats into a queue; a monitor on the falling edge
// pops and compares every accepted beat and checks data hold during stalls.
// ----------------------------------------------------------------------------
module tb_framebuffer_tile_store;
   localparam int IW    = 4;
   localparam int PW    = 32;
   localparam int PPB   = 2;
   localparam int SW    = PW * PPB;
   localparam int WORDS = 8;

   logic          aclk = 1'b0;
   logic          resetn = 1'b0;
   logic [PW-1:0] confClearColor = '0;
   logic          apply = 1'b0;
   logic          commit = 1'b0;
   logic          busy;
   logic [IW-1:0] colorIndexRead = '0;
   logic [PW-1:0] colorIn;
   logic [IW-1:0] colorIndexWrite = '0;
   logic          colorWriteEnable = 1'b0;
   logic [PW-1:0] colorOut = '0;

   always #5 aclk = ~aclk;

   framebuffer_tile_store_if #(.STREAM_WIDTH(SW)) axis ();

   framebuffer_tile_store #(
      .FRAMEBUFFER_INDEX_WIDTH(IW),
      .PIXEL_WIDTH(PW),
      .PIXEL_PER_BEAT(PPB)
   ) dut (
      .aclk(aclk),
      .resetn(resetn),
      .confClearColor(confClearColor),
      .apply(apply),
      .commit(commit),
      .busy(busy),
      .colorIndexRead(colorIndexRead),
      .colorIn(colorIn),
      .colorIndexWrite(colorIndexWrite),
      .colorWriteEnable(colorWriteEnable),
      .colorOut(colorOut),
      .m_axis(axis)
   );

   int            checks = 0;
   int            errors = 0;
   int            beats_rcv = 0;
   logic [SW:0]   exp_q[$];
   logic [PW-1:0] model [16];
   logic          stall_prev = 1'b0;
   logic [SW:0]   held = '0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // scoreboard monitor
   always @(negedge aclk) begin
      if (!resetn) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("stall_hold", {axis.tvalid, axis.tlast, axis.tdata}, {1'b1, held});
         end
         if (axis.tvalid && axis.tready) begin
            beats_rcv++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat actual=%0h required=none", {axis.tlast, axis.tdata});
            end else begin
               check("beat", {axis.tlast, axis.tdata}, exp_q.pop_front());
            end
         end
         stall_prev = axis.tvalid && !axis.tready;
         held       = {axis.tlast, axis.tdata};
      end
   end

   task automatic push_tile();
      for (int w = 0; w < WORDS; w++) begin
         exp_q.push_back({(w == WORDS - 1), model[2*w+1], model[2*w]});
      end
   endtask

   // mode 0: tready always high; mode 1: 1,0,0,1 then random
   task automatic run_commit(input int mode);
      int n;
      logic [3:0] pat;
      pat = 4'b1001;
      push_tile();
      axis.tready = 1'b1;
      commit = 1'b1;
      tick();
      commit = 1'b0;
      check("commit_busy", busy, 1'b1);
      n = 0;
      while (busy && n < 300) begin
         if (mode == 0)  axis.tready = 1'b1;
         else if (n < 4) axis.tready = pat[3-n];
         else            axis.tready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      axis.tready = 1'b1;
      check("commit_done_in_time", (n < 300), 1'b1);
      check("commit_all_beats", exp_q.size(), 0);
      check("commit_tvalid_after", axis.tvalid, 1'b0);
   endtask

   task automatic run_clear(input logic [PW-1:0] color, input logic with_commit, input logic write_during);
      int n;
      logic saw_valid;
      confClearColor = color;
      apply  = 1'b1;
      commit = with_commit;
      tick();
      apply  = 1'b0;
      commit = 1'b0;
      n = 0;
      saw_valid = 1'b0;
      while (busy && n < 50) begin
         if (write_during) begin
            colorWriteEnable = 1'b1;
            colorIndexWrite  = 4'd3;
            colorOut         = 32'hDEADBEEF;
         end
         if (axis.tvalid) saw_valid = 1'b1;
         tick();
         n++;
      end
      colorWriteEnable = 1'b0;
      check("clear_cycles", n, 8);
      check("clear_no_tvalid", saw_valid, 1'b0);
      for (int i = 0; i < 16; i++) model[i] = color;
   endtask

   initial begin
      int n;
      int base;
      axis.tready = 1'b0;
      for (int i = 0; i < 16; i++) model[i] = '0;
      #12;
      check("rst_busy", busy, 1'b0);
      check("rst_tvalid", axis.tvalid, 1'b0);
      check("rst_tlast", axis.tlast, 1'b0);
      check("rst_tdata", axis.tdata, 64'h0);
      check("rst_colorIn", colorIn, 32'h0);
      tick();
      resetn = 1'b1;
      tick();

      // clear then full-rate stream-out
      run_clear(32'hFF00FF00, 1'b0, 1'b0);
      run_commit(0);

      // pixel write then read next cycle; same-cycle write/read bypass
      colorWriteEnable = 1'b1;
      colorIndexWrite  = 4'd5;
      colorOut         = 32'h12345678;
      tick();
      colorWriteEnable = 1'b0;
      colorIndexRead   = 4'd5;
      tick();
      check("read_after_write", colorIn, 32'h12345678);
      colorIndexRead = 4'd4;
      tick();
      check("read_neighbour_lane", colorIn, 32'hFF00FF00);
      colorWriteEnable = 1'b1;
      colorIndexWrite  = 4'd6;
      colorOut         = 32'hCAFEF00D;
      colorIndexRead   = 4'd6;
      tick();
      colorWriteEnable = 1'b0;
      check("read_bypass", colorIn, 32'hCAFEF00D);
      model[5] = 32'h12345678;
      model[6] = 32'hCAFEF00D;
      run_commit(0);

      // back-pressure stream-out
      run_commit(1);

      // apply and commit together: clear only
      run_clear(32'h0A0B0C0D, 1'b1, 1'b0);
      check("apply_wins_idle", busy, 1'b0);

      // writes during clear are dropped
      run_clear(32'h55AA55AA, 1'b0, 1'b1);
      colorIndexRead = 4'd3;
      tick();
      check("clear_write_dropped", colorIn, 32'h55AA55AA);

      // reset in the middle of a stream-out, then restart
      push_tile();
      base = beats_rcv;
      axis.tready = 1'b1;
      commit = 1'b1;
      tick();
      commit = 1'b0;
      n = 0;
      while (beats_rcv < base + 3 && n < 50) begin
         tick();
         n++;
      end
      check("abort_reach_beat4", (n < 50), 1'b1);
      #2;
      resetn = 1'b0;
      #1;
      check("abort_tvalid", axis.tvalid, 1'b0);
      check("abort_busy", busy, 1'b0);
      exp_q.delete();
      tick();
      tick();
      resetn = 1'b1;
      tick();
      run_commit(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
